// File: rtl/param_delay_line.sv
// Runtime-programmable delay line built on a circular register buffer.
// Delays one WIDTH-bit stream by 1..MAX_DEPTH accepted samples, with flush and sticky range error.
module param_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 90,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [DW-1:0]    delay_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             cfg_err
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [MAX_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, wptrInc;
  logic [DW-1:0]    fill_q, fill_d, fillInc;
  logic [DW-1:0]    delay_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             cfgErr_q, cfgErr_d;

  logic [DW-1:0]    deff;
  logic             rangeErr;
  logic [DW:0]      rdSum;
  logic [AW-1:0]    rdAddr;
  logic [WIDTH-1:0] rdData;
  logic             memWe;

  // Clamp the requested delay into 1..MAX_DEPTH and flag anything outside it.
  always_comb begin
    deff     = delay_sel;
    rangeErr = 1'b0;
    if (delay_sel == '0) begin
      deff     = DW'(1);
      rangeErr = 1'b1;
    end else if (delay_sel > DW'(MAX_DEPTH)) begin
      deff     = DW'(MAX_DEPTH);
      rangeErr = 1'b1;
    end
  end

  // Oldest sample still inside the window sits D-1 slots behind the write pointer.
  always_comb begin
    rdSum = (DW+1)'(wptr_q) + (DW+1)'(MAX_DEPTH) + (DW+1)'(1) - {1'b0, deff};
    if (rdSum >= (DW+1)'(MAX_DEPTH)) begin
      rdSum = rdSum - (DW+1)'(MAX_DEPTH);
    end
    rdAddr = AW'(rdSum);
    rdData = (deff == DW'(1)) ? din : mem_q[rdAddr];
  end

  assign wptrInc = (wptr_q == AW'(MAX_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
  assign fillInc = (fill_q == DW'(MAX_DEPTH)) ? fill_q : fill_q + DW'(1);

  always_comb begin
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    cfgErr_d = cfgErr_q | rangeErr;
    memWe    = 1'b0;
    if (flush) begin
      fill_d  = '0;
      dout_d  = '0;
      valid_d = 1'b0;
    end else if (deff != delay_q) begin
      // A new delay restarts fill; stored history is reused once refilled.
      if (en) begin
        memWe   = 1'b1;
        wptr_d  = wptrInc;
        fill_d  = DW'(1);
        dout_d  = rdData;
        valid_d = (DW'(1) >= deff);
      end else begin
        fill_d  = '0;
        valid_d = 1'b0;
      end
    end else if (en) begin
      memWe   = 1'b1;
      wptr_d  = wptrInc;
      fill_d  = fillInc;
      dout_d  = rdData;
      valid_d = (fillInc >= deff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q   <= '0;
      fill_q   <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      cfgErr_q <= 1'b0;
      delay_q  <= deff;
    end else begin
      if (memWe) begin
        mem_q[wptr_q] <= din;
      end
      wptr_q   <= wptr_d;
      fill_q   <= fill_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      cfgErr_q <= cfgErr_d;
      delay_q  <= deff;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign cfg_err    = cfgErr_q;

endmodule

// File: tb/tb_param_delay_line.sv
// Directed bench for param_delay_line at WIDTH=8, MAX_DEPTH=90.
// Expected values are hand-derived from shift-register behaviour of the delay line.
module tb_param_delay_line;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [6:0] delay_sel;
  logic       flush;
  logic [7:0] dout;
  logic       dout_valid;
  logic       cfg_err;

  int vecCount;
  int missCount;

  param_delay_line #(
    .WIDTH    (8),
    .MAX_DEPTH(90)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .delay_sel (delay_sel),
    .flush     (flush),
    .dout      (dout),
    .dout_valid(dout_valid),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic e,
                               input int d, input int s);
    rst       = r;
    flush     = f;
    en        = e;
    din       = 8'(d);
    delay_sel = 7'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int expDout, input int expValid, input int expErr);
    checkOutput({tag, ".dout"}, int'(dout), expDout);
    checkOutput({tag, ".valid"}, int'(dout_valid), expValid);
    checkOutput({tag, ".cfg_err"}, int'(cfg_err), expErr);
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst = 1'b0; flush = 1'b0; en = 1'b0; din = '0; delay_sel = 7'd30;
    #2;

    // Basic delay 30, then switch to 45
    applyStimulus(1, 0, 0, 0, 30);
    checkAll("reset", 0, 0, 0);
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(0, 0, 1, n, 30);
      if (n == 29) checkOutput("d30.prevalid", int'(dout_valid), 0);
      if (n >= 30) checkAll($sformatf("d30.n%0d", n), n - 29, 1, 0);
    end
    applyStimulus(0, 0, 1, 41, 45);
    checkOutput("chg.valid", int'(dout_valid), 0);
    for (int n = 42; n <= 86; n++) begin
      applyStimulus(0, 0, 1, n, 45);
      if (n == 84) checkOutput("d45.prevalid", int'(dout_valid), 0);
      if (n >= 85) checkAll($sformatf("d45.n%0d", n), n - 44, 1, 0);
    end

    // Max delay and pointer wrap
    applyStimulus(1, 0, 0, 0, 90);
    for (int n = 1; n <= 200; n++) begin
      applyStimulus(0, 0, 1, n, 90);
      if (n == 89) checkOutput("d90.prevalid", int'(dout_valid), 0);
      if (n >= 90) begin
        checkOutput($sformatf("d90.dout.n%0d", n), int'(dout), n - 89);
        checkOutput($sformatf("d90.valid.n%0d", n), int'(dout_valid), 1);
      end
    end

    // Enable gaps at delay 4
    applyStimulus(1, 0, 0, 0, 4);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 1, k, 4);
      if (k == 3) checkOutput("gap.prevalid", int'(dout_valid), 0);
      if (k == 4) checkAll("gap.k4", 1, 1, 0);
      if (k == 6) checkAll("gap.k6", 3, 1, 0);
      applyStimulus(0, 0, 0, 99, 4);
      if (k >= 4) checkAll($sformatf("gap.hold%0d", k), k - 3, 1, 0);
    end

    // Range errors: 0 clamps to 1, 91 clamps to 90
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst.sel0.cfg_err", int'(cfg_err), 0);
    applyStimulus(0, 0, 1, 7, 0);
    checkAll("sel0.a", 7, 1, 1);
    applyStimulus(0, 0, 1, 8, 0);
    checkAll("sel0.b", 8, 1, 1);
    applyStimulus(0, 0, 1, 1, 91);
    checkOutput("sel91.chg.valid", int'(dout_valid), 0);
    checkOutput("sel91.chg.cfg_err", int'(cfg_err), 1);
    for (int n = 2; n <= 91; n++) begin
      applyStimulus(0, 0, 1, n, 91);
      if (n == 89) checkOutput("sel91.prevalid", int'(dout_valid), 0);
      if (n >= 90) checkAll($sformatf("sel91.n%0d", n), n - 89, 1, 1);
    end
    applyStimulus(1, 0, 0, 0, 30);
    checkAll("rst.clrerr", 0, 0, 0);

    // Flush mid-stream drops the sample and restarts fill
    for (int n = 1; n <= 35; n++) applyStimulus(0, 0, 1, n, 30);
    checkAll("preflush", 6, 1, 0);
    applyStimulus(0, 1, 1, 36, 30);
    checkAll("flush", 0, 0, 0);
    for (int n = 37; n <= 67; n++) begin
      applyStimulus(0, 0, 1, n, 30);
      if (n == 65) checkOutput("flush.prevalid", int'(dout_valid), 0);
      if (n >= 66) checkAll($sformatf("flush.n%0d", n), n - 29, 1, 0);
    end

    // Reset mid-stream beats flush, enable and a bad delay_sel
    applyStimulus(1, 1, 1, 68, 0);
    checkAll("rst.mid", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/param_delay_line.md
# param_delay_line

Runtime-programmable, parametrised delay line: one WIDTH-bit sample stream delayed by a selectable 1..MAX_DEPTH accepted samples, using a circular register buffer rather than per-depth shift chains. It replaces the four fixed-depth lines plus output mux in the delay-line top level with a single instance. It adds a sample enable, a fill-tracking output-valid flag, flush, and out-of-range delay detection.

## Interface

Parameters:
- WIDTH, 8: sample width in bits.
- MAX_DEPTH, 90: maximum delay in accepted samples; at least 2.
- DW, derived as clog2(MAX_DEPTH+1): width of delay_sel. Local, not overridable.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; din is accepted on an edge where en=1.
- din  in  WIDTH  input sample.
- delay_sel  in  DW  requested delay D, in accepted samples.
- flush  in  1  synchronous clear of the delay history.
- dout  out  WIDTH  delayed sample (registered).
- dout_valid  out  1  dout holds a real sample delayed by the current D.
- cfg_err  out  1  sticky flag: an out-of-range delay_sel was seen.

## Operation

- Storage: MAX_DEPTH x WIDTH register array mem, a write pointer wptr (0..MAX_DEPTH-1, wraps to 0), a held delay delay_q, and a fill counter fill that saturates at MAX_DEPTH.
- Effective delay D_eff:
  - delay_sel=0 gives D_eff=1.
  - delay_sel>MAX_DEPTH gives D_eff=MAX_DEPTH.
  - Otherwise D_eff=delay_sel.
  - In both out-of-range cases, cfg_err is set on that edge and stays 1 until rst.
- Function: behaves exactly like a D_eff-stage shift register clocked by en. After the edge that accepts sample n, dout = sample n-D_eff+1. D_eff=1 means dout = din accepted on that edge.
- Read address: (wptr - (D_eff-1)) mod MAX_DEPTH, read before the write on the same edge. The D_eff=1 case takes din directly.
- Priority per edge: rst > flush > delay change > en.
  - rst:
    - mem, wptr, fill, dout, dout_valid and cfg_err clear to 0.
    - delay_q loads D_eff.
  - flush:
    - fill=0, dout=0, dout_valid=0.
    - din is not accepted and wptr holds.
    - mem is not cleared; it is masked by fill.
    - delay_q still loads D_eff.
  - Delay change, when D_eff != delay_q:
    - delay_q loads D_eff and fill restarts.
    - With en=1: sample is written, wptr advances, fill=1, dout is computed with the new D_eff.
    - With en=0: fill=0, dout_valid=0, dout holds.
  - en=1, no change:
    - mem[wptr] gets din, wptr advances, fill increments (saturating).
    - dout is updated.
  - en=0: all state holds.
- dout_valid is 1 after any edge where the updated fill >= delay_q; otherwise 0.
- When dout_valid=0, dout carries reset, flush or stale data; consumers must ignore it.

## Timing

- Reset values: dout=0, dout_valid=0, cfg_err=0, wptr=0, fill=0, mem all zero.
- Latency: with en held high, din at edge k appears on dout after edge k+D_eff-1, i.e. D_eff-1 cycles after acceptance, plus the output register.
- dout and dout_valid change only on edges with en=1, flush, rst or a delay change; otherwise they hold.
- dout_valid first rises on the edge accepting the D_eff-th sample after reset, flush or delay change.
- Wrap-around: wptr goes from MAX_DEPTH-1 to 0 with no bubble. At D_eff=MAX_DEPTH the read address equals wptr+1 mod MAX_DEPTH, the oldest stored sample.
- delay_sel is sampled every edge; there is no handshake. Holding it stable is the user's responsibility.
- rst asserted mid-stream: all outputs are 0 after that edge regardless of en, flush or delay_sel.

## Test plan

Bench configuration: WIDTH=8, MAX_DEPTH=90; din=n on the n-th accepted sample unless stated.

- Basic delay: rst, then delay_sel=30, en=1 continuously -> dout_valid=0 through edge 29; after edge 30, dout=1 and dout_valid=1; after edge n, dout=n-29.
- Max delay and wrap: delay_sel=90, stream 200 samples -> first valid after edge 90 with dout=1; after edge 200, dout=111 with no glitch across the pointer wrap.
- Enable gaps: delay_sel=4, en alternating 1,0 -> dout holds on en=0 edges; dout_valid rises on the 4th accepted sample with dout=1; after the 6th accepted sample, dout=3.
- Delay change: streaming at delay_sel=30 (valid), switch to 45 with en=1 -> dout_valid=0 after the change edge; valid again after 45 accepted samples counting the change-edge sample; dout = that sample minus 44.
- Range errors: delay_sel=0 -> behaves as delay 1, cfg_err=1. Then delay_sel=91 -> behaves as delay 90, cfg_err stays 1. rst -> cfg_err=0.
- Flush and reset mid-stream:
  - flush=1 with en=1 at delay 30 -> dout=0, dout_valid=0, sample dropped, wptr unchanged; valid returns after 30 further samples.
  - rst mid-stream -> all outputs 0 on the next edge.
